// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// Optional feature macro: SEQ_MULT_SIGNED_EN (enables signed Booth mode).
package seq_mult_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // ALU function codes.
  typedef enum logic [1:0] {
    AluAddu,
    AluSubu,
    AluPass
  } alu_op_e;

  // Counter width needed to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_alu.sv
// WIDTH+1-bit add / subtract / pass unit with carry out.
// Optional feature macro: SEQ_MULT_SIGNED_EN (adds the subtract path).
module seq_mult_alu
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  alu_op_e        op,
  output logic [WIDTH:0] y,
  output logic           co
);

  // Select the operation; unknown codes behave as pass.
  always_comb begin
    {co, y} = {1'b0, a};
    case (op)
      AluAddu: {co, y} = {1'b0, a} + {1'b0, b};
`ifdef SEQ_MULT_SIGNED_EN
      // a - b as a + ~b + 1 so co is the usual no-borrow flag.
      AluSubu: {co, y} = {1'b0, a} + {1'b0, ~b} + {{(WIDTH + 1){1'b0}}, 1'b1};
`endif
      default: {co, y} = {1'b0, a};
    endcase
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier, one multiplier bit per clock.
// Optional feature macro: SEQ_MULT_SIGNED_EN (radix-2 Booth signed mode).
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Signed_in,
  input  logic [WIDTH-1:0]   Multiplier_in,
  input  logic [WIDTH-1:0]   Multiplicand_in,
  output logic [2*WIDTH-1:0] Product_out,
  output logic               Ready,
  output logic               Busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic             signed_q;
  logic             hist_q;
  // Upper accumulator is one bit wider so the most-negative operand cannot overflow.
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] lo_q;
  // Low for the first edge after reset release, so a mid-cycle release never starts work.
  logic             arm_q;

  logic             accept;
  alu_op_e          alu_op;
  logic [WIDTH:0]   alu_b;
  logic [WIDTH:0]   alu_y;
  logic             alu_co_unused;

`ifndef SEQ_MULT_SIGNED_EN
  logic signed_in_unused;
  assign signed_in_unused = Signed_in;
`endif

  assign accept      = Run && arm_q && (state_q != StBusy);
  assign Product_out = {acc_q[WIDTH-1:0], lo_q};

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy:  if (cnt_q == CntW'(1)) state_d = StDone;
      StDone:  if (accept) state_d = StBusy;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    Busy  = (state_q == StBusy);
    Ready = (state_q == StDone);
  end

  // Pick the ALU operation from the multiplier LSB (and Booth history in signed mode).
  always_comb begin
    alu_op = lo_q[0] ? AluAddu : AluPass;
`ifdef SEQ_MULT_SIGNED_EN
    if (signed_q) begin
      unique case ({lo_q[0], hist_q})
        2'b01:   alu_op = AluAddu;
        2'b10:   alu_op = AluSubu;
        default: alu_op = AluPass;
      endcase
    end
`endif
  end

  // Multiplicand is sign-extended only in signed mode.
  assign alu_b = {signed_q & mcand_q[WIDTH-1], mcand_q};

  seq_mult_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a  (acc_q),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y),
    .co (alu_co_unused)
  );

  // Reset arming flag.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
    end
  end

  // Datapath: load on accept, then add-and-shift once per busy cycle.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      signed_q <= 1'b0;
      hist_q   <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
    end else if (accept) begin
      cnt_q    <= CntW'(WIDTH);
      mcand_q  <= Multiplicand_in;
`ifdef SEQ_MULT_SIGNED_EN
      signed_q <= Signed_in;
`else
      signed_q <= 1'b0;
`endif
      hist_q   <= 1'b0;
      acc_q    <= '0;
      lo_q     <= Multiplier_in;
    end else if (state_q == StBusy) begin
      // Unsigned: alu_y[WIDTH] is the carry shifted in; signed: it is the sign, replicated.
      acc_q  <= {signed_q & alu_y[WIDTH], alu_y[WIDTH:1]};
      lo_q   <= {alu_y[0], lo_q[WIDTH-1:1]};
      hist_q <= lo_q[0];
      cnt_q  <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH = 32).
// Expectations follow the SEQ_MULT_SIGNED_EN setting of the build.
module tb_seq_multiplier;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           Reset;
  logic           Run;
  logic           Signed_in;
  logic [W-1:0]   Multiplier_in;
  logic [W-1:0]   Multiplicand_in;
  logic [2*W-1:0] Product_out;
  logic           Ready;
  logic           Busy;

  int n_pass  = 0;
  int n_total = 0;

  seq_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk             (clk),
    .Reset           (Reset),
    .Run             (Run),
    .Signed_in       (Signed_in),
    .Multiplier_in   (Multiplier_in),
    .Multiplicand_in (Multiplicand_in),
    .Product_out     (Product_out),
    .Ready           (Ready),
    .Busy            (Busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: presents operands with Run for one edge, then waits for Ready.
  // poke > 0 raises Run with different operands at that busy cycle to confirm it is ignored.
  task automatic do_mult(input string tag, input logic [W-1:0] mplier, input logic [W-1:0] mcand,
                         input logic sgn, input logic [63:0] exp, input int poke);
    int lat;
    Run             = 1'b1;
    Signed_in       = sgn;
    Multiplier_in   = mplier;
    Multiplicand_in = mcand;
    @(negedge clk);
    Run = 1'b0;
    check_eq({tag, " busy after accept"}, 64'(Busy), 64'd1);
    check_eq({tag, " ready low after accept"}, 64'(Ready), 64'd0);
    lat = 0;
    for (int k = 1; k <= int'(W) + 8; k++) begin
      @(negedge clk);
      if (poke > 0 && k == poke) begin
        Run             = 1'b1;
        Signed_in       = ~sgn;
        Multiplier_in   = 32'd9;
        Multiplicand_in = 32'd9;
      end else if (poke > 0 && k == poke + 1) begin
        Run = 1'b0;
      end
      if (Ready) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(W));
    check_eq({tag, " product"}, Product_out, exp);
  endtask

  task automatic check_hold(input string tag, input logic [63:0] exp);
    repeat (5) @(negedge clk);
    check_eq({tag, " ready held"}, 64'(Ready), 64'd1);
    check_eq({tag, " product held"}, Product_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset           = 1'b0;
    Run             = 1'b0;
    Signed_in       = 1'b0;
    Multiplier_in   = '0;
    Multiplicand_in = '0;
    repeat (3) @(negedge clk);
    check_eq("reset product", Product_out, 64'd0);
    check_eq("reset ready", 64'(Ready), 64'd0);
    check_eq("reset busy", 64'(Busy), 64'd0);

    // Release mid-cycle with Run already high: first edge must not accept.
    Run             = 1'b1;
    Multiplier_in   = 32'd3;
    Multiplicand_in = 32'd5;
    #2 Reset = 1'b1;
    @(negedge clk);
    check_eq("first edge after release ignored", 64'(Busy), 64'd0);

    do_mult("3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0);
    check_hold("3x5", 64'h0000_0000_0000_000F);

    // Restart straight from DONE.
    do_mult("max x max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    do_mult("run ignored in busy", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 10);
    do_mult("zero x max", 32'd0, 32'hFFFF_FFFF, 1'b0, 64'd0, 0);
    do_mult("1234 x 5678", 32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060, 0);

`ifdef SEQ_MULT_SIGNED_EN
    do_mult("signed min x min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    do_mult("signed -1 x 7", 32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 0);
    do_mult("signed 7 x -3", 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    do_mult("signed_in -1 x 2", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
`else
    do_mult("signed_in ignored", 32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE, 0);
`endif

    // Reset in the middle of an operation.
    Run             = 1'b1;
    Signed_in       = 1'b0;
    Multiplier_in   = 32'hFFFF_FFFF;
    Multiplicand_in = 32'hFFFF_FFFF;
    @(negedge clk);
    Run = 1'b0;
    repeat (15) @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    check_eq("mid-busy reset product", Product_out, 64'd0);
    check_eq("mid-busy reset busy", 64'(Busy), 64'd0);
    check_eq("mid-busy reset ready", 64'(Ready), 64'd0);
    @(negedge clk);
    #2 Reset = 1'b1;
    @(negedge clk);
    do_mult("6x7 after reset", 32'd6, 32'd7, 1'b0, 64'd42, 0);
    check_hold("6x7", 64'd42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Run, input, 1 bit: start request, sampled on clk.
REQ-005 The block SHALL have port Signed_in, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with Run.
REQ-006 The block SHALL have port Multiplier_in, input, WIDTH bits: multiplier operand, sampled with Run.
REQ-007 The block SHALL have port Multiplicand_in, input, WIDTH bits: multiplicand operand, sampled with Run.
REQ-008 The block SHALL have port Product_out, output, 2*WIDTH bits: product register, valid while Ready=1.
REQ-009 The block SHALL have port Ready, output, 1 bit: result valid and block idle-able.
REQ-010 The block SHALL have port Busy, output, 1 bit: iteration in progress.

Function
REQ-011 The block SHALL implement FSM states IDLE, BUSY, DONE; Busy=1 exactly in BUSY, Ready=1 exactly in DONE.
REQ-012 On a rising edge in IDLE or DONE with Run=1, the block SHALL latch Multiplicand_in and Signed_in, load the product register to {0, Multiplier_in}, clear the Booth history bit, load the iteration counter to WIDTH, and go to BUSY.
REQ-013 The block SHALL ignore Run while in BUSY; operands, mode and count are unaffected.
REQ-014 Each BUSY cycle, in unsigned mode, the block SHALL add the multiplicand to the upper half when the product LSB is 1, then shift the {carry, upper, lower} register right by one.
REQ-015 Each BUSY cycle, in signed mode, the block SHALL apply radix-2 Booth on {LSB, history}: 01 add, 10 subtract, 00/11 no-op; it SHALL then shift arithmetically right by one, with the upper accumulator one bit wider than WIDTH so that the most-negative operand cannot overflow.
REQ-016 The block SHALL decrement the counter once per BUSY cycle and enter DONE on the edge that completes iteration WIDTH, so that Ready is high exactly WIDTH edges after the accepting edge.
REQ-017 The block SHALL hold Product_out constant in DONE until the next accepted Run.
REQ-018 Product_out during BUSY is an intermediate value and SHALL NOT be relied on.
REQ-019 On an edge in DONE with Run=1, the block SHALL restart per REQ-012 and drop Ready on that edge, with no IDLE cycle.
REQ-020 The block SHALL stay in DONE indefinitely while Run=0; it returns to IDLE only via reset.

Reset
REQ-021 On Reset low, at any time including mid-BUSY, the block SHALL immediately force state IDLE, Product_out=0, Ready=0, Busy=0, counter=0, latched operands=0, and latched mode=0.
REQ-022 The block SHALL NOT accept Run on the first rising edge after Reset deasserts if the release occurs within that cycle; it SHALL accept Run on the following edge.

Configuration
REQ-023 With macro SEQ_MULT_SIGNED_EN defined, the block SHALL include signed Booth mode per REQ-015.
REQ-024 Without SEQ_MULT_SIGNED_EN, the block SHALL ignore Signed_in, force latched mode to 0, and omit the subtract path; all operations are unsigned.

Structure
REQ-025 Package seq_mult_pkg SHALL hold the FSM state enum, the ALU function codes (ADDU, SUBU, PASS), and the counter-width constant computed from WIDTH.
REQ-026 The block SHALL use one sub-module, seq_mult_alu (WIDTH+1-bit add/subtract/pass with carry out), instantiated once.

Verification
REQ-027 WIDTH=32, unsigned, 3 x 5: Ready rises 32 edges after the Run edge; Product_out = 0x000000000000000F.
REQ-028 WIDTH=32, unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001.
REQ-029 WIDTH=32, signed (macro on), 0x80000000 x 0x80000000 -> 0x4000000000000000; 0xFFFFFFFF x 0x00000007 -> 0xFFFFFFFFFFFFFFF9.
REQ-030 Run=1 with new operands 10 cycles into BUSY -> ignored; the original result appears on schedule.
REQ-031 Reset low at iteration 16 -> outputs zero immediately; a fresh Run of 6 x 7 -> 42 after 32 edges.
REQ-032 Macro off, Signed_in=1, 0xFFFFFFFF x 2 -> 0x00000001FFFFFFFE (unsigned result).
